ddr3_pll_phase_ctrl: RTL and testbench



---
 rtl/ddr3_pll_phase_pkg.sv | 37 +++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/ddr3_pll_phase_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_ddr3_pll_phase_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pll_phase_pkg.sv
// Shared types and constants for the DDR3 PLL phase-adjust controller.
package ddr3_pll_phase_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP     = 4'd0,
        ST_WAIT_LOCK = 4'd1,
        ST_IDLE      = 4'd2,
        ST_SETUP     = 4'd3,
        ST_ROT_HI    = 4'd4,
        ST_ROT_LO    = 4'd5,
        ST_LOAD      = 4'd6,
        ST_DONE      = 4'd7
    } state_e;

    localparam logic [1:0] SEL_OUT0 = 2'd0;
    localparam logic [1:0] SEL_OUT2 = 2'd1;
    localparam logic [1:0] SEL_OUT3 = 2'd2;
    localparam logic [1:0] SEL_ALL  = 2'd3;

    localparam int CYC_CNT_W = 16;
    localparam int STEP_W    = 8;

    localparam logic [CYC_CNT_W-1:0] CYC_ONE  = {{(CYC_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]    STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    // Bit 0 = OUT0, bit 1 = OUT2, bit 2 = OUT3
    function automatic logic [2:0] sel_mask(input logic [1:0] outsel);
        case (outsel)
            SEL_OUT0: sel_mask = 3'b001;
            SEL_OUT2: sel_mask = 3'b010;
            SEL_OUT3: sel_mask = 3'b100;
            SEL_ALL:  sel_mask = 3'b111;
            default:  sel_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the fabric clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lock_async,
    output logic lock_sync
);

    logic meta_r;
    logic sync_r;

    // Metastability-settling chain, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= lock_async;
            sync_r <= meta_r;
        end
    end

    assign lock_sync = sync_r;

endmodule

// File: rtl/ddr3_pll_phase_ctrl.sv
// DDR3 CCC PLL power-up/lock sequencer and dynamic phase-shift pulse-train generator.
module ddr3_pll_phase_ctrl
    import ddr3_pll_phase_pkg::*;
#(
    parameter int PD_CYC       = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int ROT_HIGH_CYC = 4,
    parameter int ROT_LOW_CYC  = 4,
    parameter int LOAD_CYC     = 4,
    parameter int PHASE_CNT_W  = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic [1:0]             REQ_OUTSEL,
    input  logic                   REQ_DIR,
    input  logic [STEP_W-1:0]      REQ_STEPS,
    input  logic                   PLL_LOCK_0,
    output logic                   PLL_POWERDOWN_N_0,
    output logic                   PHASE_OUT0_SEL_0,
    output logic                   PHASE_OUT2_SEL_0,
    output logic                   PHASE_OUT3_SEL_0,
    output logic                   PHASE_DIRECTION_0,
    output logic                   PHASE_ROTATE_0,
    output logic                   LOAD_PHASE_N_0,
    output logic                   LOCKED,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR_TIMEOUT,
    output logic                   ERR_LOCK_LOST,
    output logic [PHASE_CNT_W-1:0] PHASE_POS0,
    output logic [PHASE_CNT_W-1:0] PHASE_POS2,
    output logic [PHASE_CNT_W-1:0] PHASE_POS3
);

    localparam logic [CYC_CNT_W-1:0] PD_LAST = CYC_CNT_W'(PD_CYC - 1);
    localparam logic [CYC_CNT_W-1:0] TO_LAST = CYC_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_CNT_W-1:0] HI_LAST = CYC_CNT_W'(ROT_HIGH_CYC - 1);
    localparam logic [CYC_CNT_W-1:0] LO_LAST = CYC_CNT_W'(ROT_LOW_CYC - 1);
    localparam logic [CYC_CNT_W-1:0] LD_LAST = CYC_CNT_W'(LOAD_CYC - 1);

    state_e                 state_r, state_nxt_s;
    logic [CYC_CNT_W-1:0]   cyc_cnt_r;
    logic [STEP_W-1:0]      steps_r;
    logic [1:0]             outsel_r, op_sel_s;
    logic                   dir_r, op_dir_s;
    logic                   lock_sync_s, in_op_s;
    logic                   accept_s, rot_exit_s, timeout_s, lock_lost_s;
    logic [2:0]             mask_s, upd_mask_s, sel_nxt_s, sel_r;
    logic                   pd_n_nxt_s, dir_nxt_s, rot_nxt_s, load_n_nxt_s;
    logic                   ready_nxt_s, busy_nxt_s, done_nxt_s, locked_nxt_s;
    logic                   pd_n_r, dir_out_r, rot_r, load_n_r;
    logic                   ready_r, busy_r, done_r, locked_r, err_to_r, err_ll_r;
    logic [PHASE_CNT_W-1:0] pos0_r, pos2_r, pos3_r, delta_s;

    pll_lock_sync u_lock_sync (
        .clk        (CLK),
        .rst        (RESET),
        .lock_async (PLL_LOCK_0),
        .lock_sync  (lock_sync_s)
    );

    assign in_op_s    = state_r inside {ST_IDLE, ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD, ST_DONE};
    // On the accept edge the request fields are not yet registered, so look at the port
    assign op_sel_s   = accept_s ? REQ_OUTSEL : outsel_r;
    assign op_dir_s   = accept_s ? REQ_DIR : dir_r;
    assign mask_s     = sel_mask(op_sel_s);
    assign upd_mask_s = sel_mask(outsel_r);
    assign delta_s    = dir_r ? {{(PHASE_CNT_W-1){1'b0}}, 1'b1} : {PHASE_CNT_W{1'b1}};

    // Next-state logic plus the single-cycle events that steer the datapath
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        rot_exit_s  = 1'b0;
        timeout_s   = 1'b0;
        lock_lost_s = 1'b0;
        if (in_op_s && !lock_sync_s) begin
            lock_lost_s = 1'b1;
            state_nxt_s = ST_WAIT_LOCK;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (cyc_cnt_r == PD_LAST) state_nxt_s = ST_WAIT_LOCK;
                    else                      state_nxt_s = ST_PWRUP;
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (cyc_cnt_r == TO_LAST) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = ST_PWRUP;
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_IDLE: begin
                    if (REQ_VALID && ready_r) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (steps_r == '0) state_nxt_s = ST_LOAD;
                    else               state_nxt_s = ST_ROT_HI;
                end
                ST_ROT_HI: begin
                    if (cyc_cnt_r == HI_LAST) begin
                        rot_exit_s  = 1'b1;
                        state_nxt_s = ST_ROT_LO;
                    end else begin
                        state_nxt_s = ST_ROT_HI;
                    end
                end
                ST_ROT_LO: begin
                    if (cyc_cnt_r != LO_LAST) state_nxt_s = ST_ROT_LO;
                    else if (steps_r != '0)   state_nxt_s = ST_ROT_HI;
                    else                      state_nxt_s = ST_LOAD;
                end
                ST_LOAD: begin
                    if (cyc_cnt_r == LD_LAST) state_nxt_s = ST_DONE;
                    else                      state_nxt_s = ST_LOAD;
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_PWRUP;
            endcase
        end
    end

    // Output decode from the upcoming state so every pin comes straight from a flop
    always_comb begin
        pd_n_nxt_s   = 1'b1;
        sel_nxt_s    = 3'b000;
        dir_nxt_s    = 1'b0;
        rot_nxt_s    = 1'b0;
        load_n_nxt_s = 1'b1;
        ready_nxt_s  = 1'b0;
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        locked_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_PWRUP:     pd_n_nxt_s = 1'b0;
            ST_WAIT_LOCK: pd_n_nxt_s = 1'b1;
            ST_IDLE: begin
                ready_nxt_s  = 1'b1;
                locked_nxt_s = lock_sync_s;
            end
            ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD: begin
                busy_nxt_s   = 1'b1;
                locked_nxt_s = lock_sync_s;
                sel_nxt_s    = mask_s;
                dir_nxt_s    = op_dir_s;
                rot_nxt_s    = (state_nxt_s == ST_ROT_HI);
                load_n_nxt_s = (state_nxt_s != ST_LOAD);
            end
            ST_DONE: begin
                done_nxt_s   = 1'b1;
                locked_nxt_s = lock_sync_s;
            end
            default: pd_n_nxt_s = 1'b0;
        endcase
    end

    // State register and the shared width/timeout counter, restarted on every transition
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_PWRUP;
            cyc_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            cyc_cnt_r <= (state_nxt_s != state_r) ? '0 : cyc_cnt_r + CYC_ONE;
        end
    end

    // Captured request fields and remaining rotate steps
    always_ff @(posedge CLK) begin
        if (RESET) begin
            outsel_r <= 2'd0;
            dir_r    <= 1'b0;
            steps_r  <= '0;
        end else if (accept_s) begin
            outsel_r <= REQ_OUTSEL;
            dir_r    <= REQ_DIR;
            steps_r  <= REQ_STEPS;
        end else if (rot_exit_s) begin
            steps_r  <= steps_r - STEP_ONE;
        end
    end

    // Registered pin outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pd_n_r    <= 1'b0;
            sel_r     <= 3'b000;
            dir_out_r <= 1'b0;
            rot_r     <= 1'b0;
            load_n_r  <= 1'b1;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            pd_n_r    <= pd_n_nxt_s;
            sel_r     <= sel_nxt_s;
            dir_out_r <= dir_nxt_s;
            rot_r     <= rot_nxt_s;
            load_n_r  <= load_n_nxt_s;
            ready_r   <= ready_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            locked_r  <= locked_nxt_s;
        end
    end

    // Phase positions wrap in two's complement; lock loss forgets them since the PLL relocks at zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pos0_r   <= '0;
            pos2_r   <= '0;
            pos3_r   <= '0;
            err_to_r <= 1'b0;
            err_ll_r <= 1'b0;
        end else begin
            if (timeout_s) err_to_r <= 1'b1;
            if (lock_lost_s) begin
                err_ll_r <= 1'b1;
                pos0_r   <= '0;
                pos2_r   <= '0;
                pos3_r   <= '0;
            end else if (rot_exit_s) begin
                if (upd_mask_s[0]) pos0_r <= pos0_r + delta_s;
                if (upd_mask_s[1]) pos2_r <= pos2_r + delta_s;
                if (upd_mask_s[2]) pos3_r <= pos3_r + delta_s;
            end
        end
    end

    assign PLL_POWERDOWN_N_0 = pd_n_r;
    assign PHASE_OUT0_SEL_0  = sel_r[0];
    assign PHASE_OUT2_SEL_0  = sel_r[1];
    assign PHASE_OUT3_SEL_0  = sel_r[2];
    assign PHASE_DIRECTION_0 = dir_out_r;
    assign PHASE_ROTATE_0    = rot_r;
    assign LOAD_PHASE_N_0    = load_n_r;
    assign REQ_READY         = ready_r;
    assign LOCKED            = locked_r;
    assign BUSY              = busy_r;
    assign DONE              = done_r;
    assign ERR_TIMEOUT       = err_to_r;
    assign ERR_LOCK_LOST     = err_ll_r;
    assign PHASE_POS0        = pos0_r;
    assign PHASE_POS2        = pos2_r;
    assign PHASE_POS3        = pos3_r;

endmodule

// File: tb/tb_ddr3_pll_phase_ctrl.sv
// Self-checking bench: directed sequencing plus randomized phase requests against a timing-formula model.
module tb_ddr3_pll_phase_ctrl;

    localparam int H  = 4;
    localparam int L  = 4;
    localparam int LD = 4;
    localparam int PD = 16;
    localparam int TO = 100;
    localparam logic [12:0] RST_VEC = 13'b0_0_0_0_0_0_1_000_0_0_0;

    logic       CLK = 1'b0;
    logic       RESET, REQ_VALID, REQ_READY, REQ_DIR, PLL_LOCK_0;
    logic [1:0] REQ_OUTSEL;
    logic [7:0] REQ_STEPS;
    logic       PLL_POWERDOWN_N_0, PHASE_OUT0_SEL_0, PHASE_OUT2_SEL_0, PHASE_OUT3_SEL_0;
    logic       PHASE_DIRECTION_0, PHASE_ROTATE_0, LOAD_PHASE_N_0;
    logic       LOCKED, BUSY, DONE, ERR_TIMEOUT, ERR_LOCK_LOST;
    logic [7:0] PHASE_POS0, PHASE_POS2, PHASE_POS3;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] mpos [3];
    logic       m_err_to, m_err_ll;
    logic [12:0] obs_v;

    always #5 CLK = ~CLK;

    ddr3_pll_phase_ctrl #(.LOCK_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OUTSEL(REQ_OUTSEL), .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .PLL_LOCK_0(PLL_LOCK_0), .PLL_POWERDOWN_N_0(PLL_POWERDOWN_N_0),
        .PHASE_OUT0_SEL_0(PHASE_OUT0_SEL_0), .PHASE_OUT2_SEL_0(PHASE_OUT2_SEL_0),
        .PHASE_OUT3_SEL_0(PHASE_OUT3_SEL_0), .PHASE_DIRECTION_0(PHASE_DIRECTION_0),
        .PHASE_ROTATE_0(PHASE_ROTATE_0), .LOAD_PHASE_N_0(LOAD_PHASE_N_0),
        .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR_TIMEOUT(ERR_TIMEOUT),
        .ERR_LOCK_LOST(ERR_LOCK_LOST), .PHASE_POS0(PHASE_POS0),
        .PHASE_POS2(PHASE_POS2), .PHASE_POS3(PHASE_POS3)
    );

    assign obs_v = {PLL_POWERDOWN_N_0, REQ_READY, LOCKED, BUSY, DONE, PHASE_ROTATE_0,
                    LOAD_PHASE_N_0, PHASE_OUT0_SEL_0, PHASE_OUT2_SEL_0, PHASE_OUT3_SEL_0,
                    PHASE_DIRECTION_0, ERR_TIMEOUT, ERR_LOCK_LOST};

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_pos0"}, 32'(PHASE_POS0), 32'(mpos[0]));
        check({tag, "_pos2"}, 32'(PHASE_POS2), 32'(mpos[1]));
        check({tag, "_pos3"}, 32'(PHASE_POS3), 32'(mpos[2]));
    endtask

    // Pin vector t cycles after the accept edge; mask order is {OUT0, OUT2, OUT3}
    function automatic logic [12:0] req_vec(input int t, input int s, input logic [2:0] m, input logic dr);
        int   d, rot_end;
        logic busy, rot, load_n;
        rot_end = 2 + s * (H + L);
        d       = rot_end + LD;
        busy    = (t >= 1) && (t <= d - 1);
        rot     = (t >= 2) && (t < rot_end) && (((t - 2) % (H + L)) < H);
        load_n  = !((t >= rot_end) && (t < d));
        return {1'b1, (t == d + 1), 1'b1, busy, (t == d), rot, load_n,
                busy ? m : 3'b000, busy & dr, m_err_to, m_err_ll};
    endfunction

    function automatic logic [2:0] mask_of(input logic [1:0] os);
        case (os)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 100) begin
            cyc();
            w++;
        end
        check({tag, "_ready"}, 32'(REQ_READY), 32'(1'b1));
    endtask

    task automatic launch(input logic [1:0] os, input logic dr, input int s);
        REQ_VALID  = 1'b1;
        REQ_OUTSEL = os;
        REQ_DIR    = dr;
        REQ_STEPS  = 8'(s);
        cyc();
        REQ_VALID  = 1'b0;
        REQ_OUTSEL = 2'($urandom);
        REQ_DIR    = 1'($urandom);
        REQ_STEPS  = 8'($urandom);
    endtask

    task automatic do_req(input logic [1:0] os, input logic dr, input int s, input string tag);
        logic [2:0] m;
        int         d;
        m = mask_of(os);
        d = 2 + s * (H + L) + LD;
        wait_ready(tag);
        launch(os, dr, s);
        for (int t = 1; t <= d + 1; t++) begin
            check($sformatf("%s_t%0d", tag, t), 32'(obs_v), 32'(req_vec(t, s, m, dr)));
            if (t <= d) cyc();
        end
        for (int i = 0; i < 3; i++) begin
            if (m[2 - i]) mpos[i] = dr ? mpos[i] + 8'(s) : mpos[i] - 8'(s);
        end
        check_pos(tag);
    endtask

    initial begin
        logic [12:0] ev;
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_OUTSEL = 2'd0; REQ_DIR = 1'b0;
        REQ_STEPS = 8'd0; PLL_LOCK_0 = 1'b0;
        m_err_to = 1'b0; m_err_ll = 1'b0;
        for (int i = 0; i < 3; i++) mpos[i] = 8'd0;

        // Reset values, then power-down release and lock acquisition
        repeat (3) cyc();
        check("reset_vec", 32'(obs_v), 32'(RST_VEC));
        check_pos("reset");
        RESET = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            ev = RST_VEC;
            ev[12] = (i >= PD);
            check($sformatf("pwrup_i%0d", i), 32'(obs_v), 32'(ev));
        end
        PLL_LOCK_0 = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            ev = RST_VEC;
            ev[12] = 1'b1;
            ev[11] = (j == 3);
            ev[10] = (j == 3);
            check($sformatf("lock_j%0d", j), 32'(obs_v), 32'(ev));
        end

        // Directed requests from the plan, then the 255-step wrap boundary
        do_req(2'd0, 1'b1, 2, "out0_adv2");
        check("out0_adv2_const", 32'(PHASE_POS0), 32'(8'd2));
        do_req(2'd3, 1'b0, 3, "all_ret3");
        check("all_ret3_const", 32'(PHASE_POS2), 32'(8'hFD));
        do_req(2'd1, 1'b1, 0, "zero_steps");
        do_req(2'd2, 1'b1, 255, "out3_adv255");

        // Randomized requests
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) cyc();
            do_req(2'($urandom), 1'($urandom), int'($urandom_range(0, 12)), $sformatf("rnd%0d", r));
        end

        // Lock loss during the first rotate-high of a 10-step request
        wait_ready("lostlk");
        launch(2'd3, 1'b1, 10);
        for (int t = 1; t <= 5; t++) begin
            check($sformatf("lostlk_t%0d", t), 32'(obs_v), 32'(req_vec(t, 10, 3'b111, 1'b1)));
            if (t == 3) PLL_LOCK_0 = 1'b0;
            cyc();
        end
        m_err_ll = 1'b1;
        for (int i = 0; i < 3; i++) mpos[i] = 8'd0;
        ev = 13'b1_0_0_0_0_0_1_000_0_0_1;
        for (int t = 6; t <= 25; t++) begin
            check($sformatf("lostlk_t%0d", t), 32'(obs_v), 32'(ev));
            cyc();
        end
        check_pos("lostlk");
        PLL_LOCK_0 = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            ev = 13'b1_0_0_0_0_0_1_000_0_0_1;
            ev[11] = (j == 3);
            ev[10] = (j == 3);
            check($sformatf("relock_j%0d", j), 32'(obs_v), 32'(ev));
        end
        do_req(2'($urandom), 1'($urandom), int'($urandom_range(1, 6)), "after_relock");

        // Reset in the middle of a request, then lock never arrives
        wait_ready("midrst");
        launch(2'd0, 1'b1, 5);
        repeat (3) cyc();
        RESET = 1'b1;
        PLL_LOCK_0 = 1'b0;
        cyc();
        m_err_ll = 1'b0;
        for (int i = 0; i < 3; i++) mpos[i] = 8'd0;
        check("midrst_vec", 32'(obs_v), 32'(RST_VEC));
        check_pos("midrst");
        cyc();
        RESET = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            ev = RST_VEC;
            ev[12] = ((i % (PD + TO)) >= PD);
            ev[1]  = (i >= PD + TO);
            check($sformatf("timeout_i%0d", i), 32'(obs_v), 32'(ev));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
